// File: rtl/elevator_pkg.sv
// Shared definitions for the 4-floor elevator: floor encodings, floor
// vector sizing and the call-panel state enum.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  typedef enum logic [FLOOR_W-1:0] {
    FLOOR_A = 2'd0,
    FLOOR_B = 2'd1,
    FLOOR_C = 2'd2,
    FLOOR_D = 2'd3
  } floor_t;

  typedef enum logic {
    IDLE = 1'b0,
    DOOR = 1'b1
  } panel_state_t;

endpackage

// File: rtl/btn_edge_det.sv
// Per-floor rising-edge detector for the call buttons: a held button
// yields a single one-cycle press.
module btn_edge_det
  import elevator_pkg::*;
#(
  parameter int W = NUM_FLOORS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press
);

  logic [W-1:0] btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel: latches button presses into requests and holds the served
// request high for a door dwell. Optional macro DOOR_REOPEN_EN lets a press
// of the served floor's button restart the dwell.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int NFLOORS = NUM_FLOORS,
  parameter int DWELL   = 8,
  parameter int CW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0] floor,
  output logic [NFLOORS-1:0] req,
  output logic               door_open,
  output logic [FLOOR_W-1:0] served_floor,
  output logic               pending
);

  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  logic [NFLOORS-1:0] press;
  logic [NFLOORS-1:0] served_mask;
  logic [NFLOORS-1:0] clr_mask;
  logic [CW-1:0]      cnt;
  logic               at_served;
  logic               reopen;
  logic               serve_done;
  panel_state_t       state;

  btn_edge_det #(
    .W(NFLOORS)
  ) u_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press)
  );

  always_comb begin
    served_mask = {{(NFLOORS-1){1'b0}}, 1'b1} << served_floor;
    at_served   = (state == DOOR) && (floor == served_floor);
`ifdef DOOR_REOPEN_EN
    reopen      = at_served && press[served_floor];
`else
    reopen      = 1'b0;
`endif
    serve_done  = at_served && !reopen && (cnt == '0);
    clr_mask    = serve_done ? served_mask : '0;
  end

  // Clear beats a same-edge press of the served floor: that press counts as served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req          <= '0;
      door_open    <= 1'b0;
      served_floor <= '0;
      cnt          <= '0;
    end else begin
      req <= (req | press) & ~clr_mask;
      case (state)
        IDLE: begin
          if (req[floor]) begin
            state        <= DOOR;
            door_open    <= 1'b1;
            served_floor <= floor;
            cnt          <= RELOAD;
          end
        end
        DOOR: begin
          if (!at_served) begin
            // Elevator left before the dwell ended; the request stays pending.
            state     <= IDLE;
            door_open <= 1'b0;
          end else if (reopen) begin
            cnt <= RELOAD;
          end else if (serve_done) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          door_open <= 1'b0;
        end
      endcase
    end
  end

  assign pending = |req;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel: a cycle-by-cycle vector table
// plus hand-written sequences for reset, clear-edge press and held buttons.
module tb_elevator_call_panel;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [1:0] floor;
  logic [3:0] req;
  logic       door_open;
  logic [1:0] served_floor;
  logic       pending;

  int total  = 0;
  int passed = 0;

  elevator_call_panel #(.NFLOORS(4), .DWELL(8), .CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .floor       (floor),
    .req         (req),
    .door_open   (door_open),
    .served_floor(served_floor),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] floor;
    logic [3:0] req;
    logic       door;
    logic [1:0] served;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input logic [3:0] b, input logic [1:0] f);
    @(negedge clk);
    btn   = b;
    floor = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] f);
    @(negedge clk);
    rst   = 1'b1;
    btn   = 4'b0000;
    floor = f;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t v(input logic [3:0] b, input logic [1:0] f,
                             input logic [3:0] r, input logic d, input logic [1:0] s);
    vec_t x;
    x.btn = b; x.floor = f; x.req = r; x.door = d; x.served = s;
    return x;
  endfunction

  initial begin
    int door_cycles;
    int services;
    logic prev_door;

    // Press at floor A, presses of C and D during the dwell, service at C,
    // early departure to D, service at D.
    tbl[0]  = v(4'b0000, 2'd0, 4'b0000, 1'b0, 2'd0);
    tbl[1]  = v(4'b0001, 2'd0, 4'b0001, 1'b0, 2'd0);
    tbl[2]  = v(4'b0001, 2'd0, 4'b0001, 1'b1, 2'd0);
    tbl[3]  = v(4'b0001, 2'd0, 4'b0001, 1'b1, 2'd0);
    tbl[4]  = v(4'b0101, 2'd0, 4'b0101, 1'b1, 2'd0);
    tbl[5]  = v(4'b1101, 2'd0, 4'b1101, 1'b1, 2'd0);
    tbl[6]  = v(4'b1101, 2'd0, 4'b1101, 1'b1, 2'd0);
    tbl[7]  = v(4'b1100, 2'd0, 4'b1101, 1'b1, 2'd0);
    tbl[8]  = v(4'b1100, 2'd0, 4'b1101, 1'b1, 2'd0);
    tbl[9]  = v(4'b1100, 2'd0, 4'b1101, 1'b1, 2'd0);
    tbl[10] = v(4'b1100, 2'd0, 4'b1100, 1'b0, 2'd0);
    tbl[11] = v(4'b1100, 2'd0, 4'b1100, 1'b0, 2'd0);
    tbl[12] = v(4'b1100, 2'd2, 4'b1100, 1'b1, 2'd2);
    tbl[13] = v(4'b0000, 2'd2, 4'b1100, 1'b1, 2'd2);
    tbl[14] = v(4'b0000, 2'd3, 4'b1100, 1'b0, 2'd2);
    tbl[15] = v(4'b0000, 2'd3, 4'b1100, 1'b1, 2'd3);
    for (int i = 16; i <= 22; i++) tbl[i] = v(4'b0000, 2'd3, 4'b1100, 1'b1, 2'd3);
    tbl[23] = v(4'b0000, 2'd3, 4'b0100, 1'b0, 2'd3);
    tbl[24] = v(4'b0000, 2'd3, 4'b0100, 1'b0, 2'd3);

    rst   = 1'b1;
    btn   = 4'b0000;
    floor = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req",    int'(req), 0);
    chk("reset_door",   int'(door_open), 0);
    chk("reset_served", int'(served_floor), 0);
    chk("reset_pending", int'(pending), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].btn, tbl[i].floor);
      chk($sformatf("tbl%0d_req", i),     int'(req), int'(tbl[i].req));
      chk($sformatf("tbl%0d_door", i),    int'(door_open), int'(tbl[i].door));
      chk($sformatf("tbl%0d_served", i),  int'(served_floor), int'(tbl[i].served));
      chk($sformatf("tbl%0d_pending", i), int'(pending), int'(|tbl[i].req));
    end

    // Reset mid-dwell with requests at B and D.
    do_reset(2'd1);
    step(4'b1010, 2'd1);
    chk("rstmid_req_latched", int'(req), 4'b1010);
    step(4'b1010, 2'd1);
    step(4'b1010, 2'd1);
    chk("rstmid_door_before", int'(door_open), 1);
    #2 rst = 1'b1;
    btn = 4'b0000;
    #1;
    chk("rstmid_req_async",  int'(req), 0);
    chk("rstmid_door_async", int'(door_open), 0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 2'd1);
    chk("rstmid_idle_door", int'(door_open), 0);
    step(4'b0010, 2'd1);
    chk("rstmid_relatch_req", int'(req), 4'b0010);
    step(4'b0000, 2'd1);
    chk("rstmid_reserve_door", int'(door_open), 1);

    // Early departure at counter=5 with C pending: B retained, C served next.
    do_reset(2'd1);
    step(4'b0110, 2'd1);
    step(4'b0000, 2'd1);
    step(4'b0000, 2'd1);
    step(4'b0000, 2'd1);
    chk("early_door_cnt5", int'(door_open), 1);
    step(4'b0000, 2'd2);
    chk("early_door_drop", int'(door_open), 0);
    chk("early_req_kept",  int'(req), 4'b0110);
    step(4'b0000, 2'd2);
    chk("early_next_door",   int'(door_open), 1);
    chk("early_next_served", int'(served_floor), 2);

    // Press of the served floor on the clear edge.
    do_reset(2'd1);
    step(4'b0010, 2'd1);
    for (int i = 0; i < 8; i++) step(4'b0000, 2'd1);
    chk("clredge_door_last", int'(door_open), 1);
    step(4'b0010, 2'd1);
`ifdef DOOR_REOPEN_EN
    chk("clredge_door_ext", int'(door_open), 1);
    chk("clredge_req_kept", int'(req), 4'b0010);
    for (int i = 0; i < 7; i++) step(4'b0010, 2'd1);
    chk("clredge_door_end", int'(door_open), 1);
    step(4'b0010, 2'd1);
    chk("clredge_door_fall", int'(door_open), 0);
    chk("clredge_req_clr",   int'(req), 0);
`else
    chk("clredge_door_fall", int'(door_open), 0);
    chk("clredge_req_clr",   int'(req), 0);
    step(4'b0010, 2'd1);
    chk("clredge_no_reserve", int'(door_open), 0);
    chk("clredge_req_stays0", int'(req), 0);
`endif

    // Held button at floor D: one service only.
    do_reset(2'd3);
    door_cycles = 0;
    services    = 0;
    prev_door   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(4'b1000, 2'd3);
      if (door_open) door_cycles++;
      if (door_open && !prev_door) services++;
      prev_door = door_open;
    end
    chk("held_door_cycles", door_cycles, 8);
    chk("held_services",    services, 1);
    chk("held_req_final",   int'(req), 0);
    chk("held_pending",     int'(pending), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
